boreal_wdt_pet_master: RTL and testbench

//   AXI4-Lite initiator that services the boreal watchdog from the control side.

---
 rtl/boreal_wdt_pkg.sv | 37 +++
 rtl/boreal_pet_interval_timer.sv | 49 ++++
 rtl/boreal_wdt_pet_master.sv | 237 +++++++++++++++++++++++
 tb/tb_boreal_wdt_pet_master.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/boreal_wdt_pkg.sv
// Shared definitions for the boreal watchdog pet master.
// Holds the watchdog register map, the pet magic word, the AXI response codes,
// the master FSM state type and a helper that forms absolute register addresses.
package boreal_wdt_pkg;

    localparam logic [7:0]  WDT_STATUS_OFS = 8'h00;
    localparam logic [7:0]  WDT_PET_OFS    = 8'h04;
    localparam logic [7:0]  WDT_FORCE_OFS  = 8'h08;

    localparam logic [31:0] WDT_PET_MAGIC  = 32'h1CEB_00DA;
    localparam logic [31:0] WDT_FORCE_VAL  = 32'h0000_0001;

    localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0]  AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA
    } pet_master_state_t;

    // Which pending request owns the write currently in flight.
    typedef enum logic {
        WR_KIND_FORCE,
        WR_KIND_PET
    } wr_kind_t;

    // Absolute address of a watchdog register; wraps at 32 bits.
    function automatic logic [31:0] wdt_reg_addr(input logic [31:0] base,
                                                 input logic [7:0]  ofs);
        return base + {24'd0, ofs};
    endfunction

endpackage

// File: rtl/boreal_pet_interval_timer.sv
// Reloadable down-counter that emits a one-cycle pet_due_o pulse every
// PET_INTERVAL cycles while pet_en_i is high. Dropping pet_en_i reloads the
// count, so the first pulse after enabling arrives PET_INTERVAL cycles later.
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset (reloads the counter)
//   pet_en_i   enables counting
//   pet_due_o  one-cycle pulse when the interval elapses
module boreal_pet_interval_timer #(
    parameter int unsigned PET_INTERVAL = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pet_en_i,
    output logic pet_due_o
);

    localparam int unsigned     CW     = (PET_INTERVAL > 2) ? $clog2(PET_INTERVAL) : 1;
    localparam logic [CW-1:0]   RELOAD = CW'(PET_INTERVAL - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          due_q, due_d;

    always_comb begin
        cnt_d = cnt_q;
        due_d = 1'b0;
        if (!pet_en_i) begin
            cnt_d = RELOAD;
        end else if (cnt_q == '0) begin
            cnt_d = RELOAD;
            due_d = 1'b1;
        end else begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= RELOAD;
            due_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            due_q <= due_d;
        end
    end

    assign pet_due_o = due_q;

endmodule

// File: rtl/boreal_wdt_pet_master.sv
// AXI4-Lite initiator servicing the boreal watchdog: periodic PET writes,
// on-demand FORCE_SAFE writes and STATUS reads, with fixed-priority
// arbitration (force > pet > status), error and missed-pet reporting.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   pet_en                          enables periodic pet generation
//   force_safe_req, status_rd_req   one-cycle request pulses
//   status_data, status_valid       last STATUS rdata and its update pulse
//   pet_count, missed_pets          saturating counters
//   err_sticky                      any non-OKAY response since reset
//   busy                            FSM not idle
//   m_axi_*                         AXI4-Lite master port (AW, W, B, AR, R)
// Build option: define BOREAL_PET_RETRY_EN to retry a failed write up to
// MAX_RETRY times with the same address and data.
module boreal_wdt_pet_master
    import boreal_wdt_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned PET_INTERVAL = 8,
    parameter int unsigned MAX_RETRY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pet_en,
    input  logic        force_safe_req,
    input  logic        status_rd_req,
    output logic [31:0] status_data,
    output logic        status_valid,
    output logic [15:0] pet_count,
    output logic [15:0] missed_pets,
    output logic        err_sticky,
    output logic        busy,
    output logic [31:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

`ifdef BOREAL_PET_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif
    localparam logic [7:0] RETRY_LIMIT = 8'(RETRY_EN ? MAX_RETRY : 0);

    pet_master_state_t state_q, state_d;
    wr_kind_t          kind_q, kind_d;
    logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d, araddr_q, araddr_d;
    logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
    logic [31:0] status_data_q, status_data_d;
    logic        status_valid_q, status_valid_d;
    logic [15:0] pet_count_q, pet_count_d, missed_q, missed_d;
    logic        err_q, err_d;
    logic        pet_pend_q, pet_pend_d, fs_pend_q, fs_pend_d, rd_pend_q, rd_pend_d;
    logic [7:0]  retry_q, retry_d;
    logic        pet_due, pet_clr, fs_clr, rd_clr;

    boreal_pet_interval_timer #(
        .PET_INTERVAL (PET_INTERVAL)
    ) u_timer (
        .clk_i     (clk),
        .rst_i     (rst),
        .pet_en_i  (pet_en),
        .pet_due_o (pet_due)
    );

    always_comb begin
        state_d        = state_q;
        kind_d         = kind_q;
        awaddr_d       = awaddr_q;
        wdata_d        = wdata_q;
        araddr_d       = araddr_q;
        awvalid_d      = awvalid_q;
        wvalid_d       = wvalid_q;
        arvalid_d      = arvalid_q;
        status_data_d  = status_data_q;
        status_valid_d = 1'b0;
        pet_count_d    = pet_count_q;
        missed_d       = missed_q;
        err_d          = err_q;
        retry_d        = retry_q;
        pet_clr        = 1'b0;
        fs_clr         = 1'b0;
        rd_clr         = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                retry_d = '0;
                if (fs_pend_q) begin
                    state_d   = ST_WR_ADDR;
                    kind_d    = WR_KIND_FORCE;
                    awaddr_d  = wdt_reg_addr(BASE_ADDR, WDT_FORCE_OFS);
                    wdata_d   = WDT_FORCE_VAL;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end else if (pet_pend_q) begin
                    state_d   = ST_WR_ADDR;
                    kind_d    = WR_KIND_PET;
                    awaddr_d  = wdt_reg_addr(BASE_ADDR, WDT_PET_OFS);
                    wdata_d   = WDT_PET_MAGIC;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end else if (rd_pend_q) begin
                    state_d   = ST_RD_ADDR;
                    araddr_d  = wdt_reg_addr(BASE_ADDR, WDT_STATUS_OFS);
                    arvalid_d = 1'b1;
                    rd_clr    = 1'b1;
                end
            end
            ST_WR_ADDR: begin
                // AW and W retire independently; leave once neither is outstanding.
                if (m_axi_awready) awvalid_d = 1'b0;
                if (m_axi_wready)  wvalid_d  = 1'b0;
                if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (m_axi_bvalid) begin
                    state_d = ST_IDLE;
                    if (m_axi_bresp == AXI_RESP_OKAY) begin
                        pet_clr = (kind_q == WR_KIND_PET);
                        fs_clr  = (kind_q == WR_KIND_FORCE);
                        if (kind_q == WR_KIND_PET && pet_count_q != 16'hFFFF) begin
                            pet_count_d = pet_count_q + 16'd1;
                        end
                    end else begin
                        err_d = 1'b1;
                        if (retry_q != RETRY_LIMIT) begin
                            // Replay with the address/data still held in awaddr_q/wdata_q.
                            retry_d   = retry_q + 8'd1;
                            state_d   = ST_WR_ADDR;
                            awvalid_d = 1'b1;
                            wvalid_d  = 1'b1;
                        end else begin
                            pet_clr = (kind_q == WR_KIND_PET);
                            fs_clr  = (kind_q == WR_KIND_FORCE);
                        end
                    end
                end
            end
            ST_RD_ADDR: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (m_axi_rvalid) begin
                    status_data_d  = m_axi_rdata;
                    status_valid_d = 1'b1;
                    if (m_axi_rresp != AXI_RESP_OKAY) err_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new request wins over a clear in the same cycle so it is never lost.
        pet_pend_d = (pet_pend_q && !pet_clr) || pet_due;
        fs_pend_d  = (fs_pend_q && !fs_clr) || force_safe_req;
        rd_pend_d  = (rd_pend_q && !rd_clr) || status_rd_req;
        if (pet_due && pet_pend_q && !pet_clr && missed_q != 16'hFFFF) begin
            missed_d = missed_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            kind_q         <= WR_KIND_FORCE;
            awaddr_q       <= '0;
            wdata_q        <= '0;
            araddr_q       <= '0;
            awvalid_q      <= 1'b0;
            wvalid_q       <= 1'b0;
            arvalid_q      <= 1'b0;
            status_data_q  <= '0;
            status_valid_q <= 1'b0;
            pet_count_q    <= '0;
            missed_q       <= '0;
            err_q          <= 1'b0;
            pet_pend_q     <= 1'b0;
            fs_pend_q      <= 1'b0;
            rd_pend_q      <= 1'b0;
            retry_q        <= '0;
        end else begin
            state_q        <= state_d;
            kind_q         <= kind_d;
            awaddr_q       <= awaddr_d;
            wdata_q        <= wdata_d;
            araddr_q       <= araddr_d;
            awvalid_q      <= awvalid_d;
            wvalid_q       <= wvalid_d;
            arvalid_q      <= arvalid_d;
            status_data_q  <= status_data_d;
            status_valid_q <= status_valid_d;
            pet_count_q    <= pet_count_d;
            missed_q       <= missed_d;
            err_q          <= err_d;
            pet_pend_q     <= pet_pend_d;
            fs_pend_q      <= fs_pend_d;
            rd_pend_q      <= rd_pend_d;
            retry_q        <= retry_d;
        end
    end

    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = (state_q == ST_WR_RESP);
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = (state_q == ST_RD_DATA);
    assign status_data   = status_data_q;
    assign status_valid  = status_valid_q;
    assign pet_count     = pet_count_q;
    assign missed_pets   = missed_q;
    assign err_sticky    = err_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_boreal_wdt_pet_master.sv
// Directed bench for boreal_wdt_pet_master with a behavioural AXI4-Lite slave.
module tb_boreal_wdt_pet_master;
    import boreal_wdt_pkg::*;

    logic        clk = 1'b0;
    logic        rst, pet_en, force_safe_req, status_rd_req;
    logic [31:0] status_data;
    logic        status_valid, err_sticky, busy;
    logic [15:0] pet_count, missed_pets;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [3:0]  m_axi_wstrb;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;

    always #5 clk = ~clk;

    boreal_wdt_pet_master #(
        .BASE_ADDR    (32'h0000_0000),
        .PET_INTERVAL (8),
        .MAX_RETRY    (2)
    ) dut (
        .clk(clk), .rst(rst), .pet_en(pet_en), .force_safe_req(force_safe_req),
        .status_rd_req(status_rd_req), .status_data(status_data), .status_valid(status_valid),
        .pet_count(pet_count), .missed_pets(missed_pets), .err_sticky(err_sticky), .busy(busy),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    // Slave configuration and observation.
    int          aw_delay = 0, b_delay = 0;
    logic [1:0]  bresp_cfg = AXI_RESP_OKAY;
    logic [31:0] rdata_cfg = '0;
    int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0;
    int          aw_cyc = 0, w_cyc = 0, aw_unstable = 0, sv_cnt = 0;
    logic [31:0] aw_log [64];
    logic [31:0] w_log  [64];
    logic [31:0] last_araddr = 32'hFFFF_FFFF;
    logic [3:0]  last_wstrb = 4'h0;
    int          aw_wait = 0, b_wait = 0;
    logic        aw_got = 0, w_got = 0, wr_owed = 0, b_fire = 0, r_owed = 0, r_fire = 0;
    logic        prev_awvalid = 0;
    logic [31:0] prev_awaddr = '0;

    // All slave activity happens on the falling edge; DUT outputs are stable then,
    // and a valid/ready pair seen here completes on the following rising edge.
    always @(negedge clk) begin
        if (rst) begin
            m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 2'b00;
            m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
            aw_wait = 0; b_wait = 0; aw_got = 0; w_got = 0; wr_owed = 0;
            b_fire = 0; r_owed = 0; r_fire = 0; prev_awvalid = 0;
        end else begin
            if (b_fire) begin m_axi_bvalid = 0; b_hs++; b_fire = 0; end
            if (wr_owed && !m_axi_bvalid) begin
                if (b_wait >= b_delay) begin
                    m_axi_bvalid = 1; m_axi_bresp = bresp_cfg; wr_owed = 0; b_wait = 0;
                end else b_wait++;
            end
            b_fire = m_axi_bvalid && m_axi_bready;

            if (r_fire) begin m_axi_rvalid = 0; r_fire = 0; end
            if (r_owed && !m_axi_rvalid) begin
                m_axi_rvalid = 1; m_axi_rdata = rdata_cfg; m_axi_rresp = AXI_RESP_OKAY; r_owed = 0;
            end
            r_fire = m_axi_rvalid && m_axi_rready;

            if (m_axi_awvalid) begin
                aw_cyc++;
                if (prev_awvalid && m_axi_awaddr != prev_awaddr) aw_unstable++;
                m_axi_awready = (aw_wait >= aw_delay);
                if (m_axi_awready) begin
                    aw_log[aw_hs[5:0]] = m_axi_awaddr; aw_hs++; aw_got = 1; aw_wait = 0;
                end else aw_wait++;
            end else m_axi_awready = 0;
            prev_awvalid = m_axi_awvalid;
            prev_awaddr  = m_axi_awaddr;

            if (m_axi_wvalid) begin
                w_cyc++; m_axi_wready = 1; w_log[w_hs[5:0]] = m_axi_wdata;
                last_wstrb = m_axi_wstrb; w_hs++; w_got = 1;
            end else m_axi_wready = 0;
            if (aw_got && w_got) begin wr_owed = 1; aw_got = 0; w_got = 0; end

            if (m_axi_arvalid) begin
                m_axi_arready = 1; last_araddr = m_axi_araddr; ar_hs++; r_owed = 1;
            end else m_axi_arready = 0;

            if (status_valid) sv_cnt++;
        end
    end

    int tests = 0, fails = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic wait_idle(input string tag);
        int quiet = 0;
        for (int i = 0; i < 200 && quiet < 4; i++) begin
            tick(1);
            if (busy) quiet = 0; else quiet++;
        end
        check_eq({tag, "_idle"}, 32'(quiet), 32'd4);
    endtask

    int a0, w0, b0, p0, m0, awc0, wc0, un0, sv0, lat, per;
    logic prev;

    initial begin
        rst = 1; pet_en = 0; force_safe_req = 0; status_rd_req = 0;
        tick(3);
        check_eq("rst_ctrl", {25'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                              m_axi_bready, m_axi_rready, busy, status_valid}, 32'd0);
        check_eq("rst_addr", m_axi_awaddr | m_axi_araddr | m_axi_wdata, 32'd0);
        check_eq("rst_cnt", {pet_count, missed_pets}, 32'd0);
        check_eq("rst_sdata", status_data, 32'd0);
        check_eq("rst_err", {31'd0, err_sticky}, 32'd0);
        rst = 0;

        // 1: periodic pets, zero-wait slave
        a0 = aw_hs;
        pet_en = 1;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (m_axi_awvalid) begin lat = i; break; end
        end
        check_eq("pet_first_latency", 32'(lat), 32'd10);
        per = 0; prev = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (m_axi_awvalid && !prev) begin per = i; break; end
            prev = m_axi_awvalid;
        end
        check_eq("pet_period", 32'(per), 32'd8);
        tick(12);
        check_eq("pet_count_3", {16'd0, pet_count}, 32'd3);
        check_eq("pet_aw_hs", 32'(aw_hs - a0), 32'd3);
        check_eq("pet_awaddr", aw_log[a0[5:0]], 32'h0000_0004);
        check_eq("pet_wdata", w_log[a0[5:0]], 32'h1CEB_00DA);
        check_eq("pet_wstrb", {28'd0, last_wstrb}, 32'hF);
        pet_en = 0;
        wait_idle("t1");
        check_eq("pet_missed_0", {16'd0, missed_pets}, 32'd0);

        // 2: force_safe_req in the same cycle as pet_due
        a0 = aw_hs; p0 = pet_count; m0 = missed_pets;
        pet_en = 1;
        tick(8);
        force_safe_req = 1;
        tick(1);
        force_safe_req = 0; pet_en = 0;
        wait_idle("t2");
        check_eq("arb_first_addr", aw_log[a0[5:0]], 32'h0000_0008);
        check_eq("arb_first_data", w_log[a0[5:0]], 32'h0000_0001);
        a0 = a0 + 1;
        check_eq("arb_second_addr", aw_log[a0[5:0]], 32'h0000_0004);
        check_eq("arb_second_data", w_log[a0[5:0]], 32'h1CEB_00DA);
        check_eq("arb_pet_delta", 32'(int'(pet_count) - p0), 32'd1);
        check_eq("arb_missed_delta", 32'(int'(missed_pets) - m0), 32'd0);

        // 3: awready delayed 3 cycles, wready immediate
        aw_delay = 3;
        a0 = aw_hs; b0 = b_hs; awc0 = aw_cyc; wc0 = w_cyc; un0 = aw_unstable;
        force_safe_req = 1; tick(1); force_safe_req = 0;
        wait_idle("t3");
        check_eq("slow_aw_cycles", 32'(aw_cyc - awc0), 32'd4);
        check_eq("slow_w_cycles", 32'(w_cyc - wc0), 32'd1);
        check_eq("slow_aw_stable", 32'(aw_unstable - un0), 32'd0);
        check_eq("slow_b_hs", 32'(b_hs - b0), 32'd1);
        check_eq("slow_awaddr", aw_log[a0[5:0]], 32'h0000_0008);
        aw_delay = 0;

        // 4: SLVERR on a pet
        bresp_cfg = AXI_RESP_SLVERR;
        a0 = aw_hs; p0 = pet_count;
        pet_en = 1; tick(8); pet_en = 0;
        wait_idle("t4");
        check_eq("err_sticky_set", {31'd0, err_sticky}, 32'd1);
        check_eq("err_pet_unchanged", 32'(int'(pet_count) - p0), 32'd0);
`ifdef BOREAL_PET_RETRY_EN
        check_eq("err_aw_hs", 32'(aw_hs - a0), 32'd3);
`else
        check_eq("err_aw_hs", 32'(aw_hs - a0), 32'd1);
`endif
        bresp_cfg = AXI_RESP_OKAY;

        // 5: STATUS read
        rdata_cfg = 32'h0000_0007; sv0 = sv_cnt;
        status_rd_req = 1; tick(1); status_rd_req = 0;
        wait_idle("t5");
        check_eq("rd_araddr", last_araddr, 32'h0000_0000);
        check_eq("rd_status_data", status_data, 32'h0000_0007);
        check_eq("rd_status_valid_cycles", 32'(sv_cnt - sv0), 32'd1);

        // 6: withheld bvalid, then reset while in WR_RESP
        b_delay = 20; m0 = missed_pets;
        pet_en = 1;
        tick(26);
        check_eq("stall_missed", 32'(int'(missed_pets) - m0), 32'd2);
        check_eq("stall_in_wr_resp", {30'd0, m_axi_bready, busy}, 32'd3);
        rst = 1; pet_en = 0;
        tick(1);
        check_eq("mid_rst_ctrl", {26'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                                  m_axi_bready, m_axi_rready, busy}, 32'd0);
        check_eq("mid_rst_cnt", {pet_count, missed_pets}, 32'd0);
        check_eq("mid_rst_err_sdata", {status_data[30:0], err_sticky}, 32'd0);
        rst = 0; b_delay = 0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
